mem_squash_ctrl: RTL and testbench

- Sits between a processor pipeline stage and an in-order memory port.
- Counts outstanding memory requests and throttles new ones at a configurable limit.
- On a squash, discards responses for every request in flight before that squash, however many there are.
- Generalises single-packet response dropping to N outstanding requests, so the front end can pipeline fetches up to p_max_inflight deep.

---
 rtl/mem_squash_pkg.sv | 15 +
 rtl/mem_squash_ctrl_updown_counter.sv | 38 +++
 rtl/mem_squash_ctrl.sv | 89 ++++++++
 tb/tb_mem_squash_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_squash_pkg.sv
// Shared types and helpers for the squash-aware memory port controller.
package mem_squash_pkg;

    // Drop FSM state; the state is fully encoded by drop_cnt != 0.
    typedef enum logic {
        STATE_PASS = 1'b0,
        STATE_DROP = 1'b1
    } state_e;

    // Width needed to hold a count in 0..max.
    function automatic int cnt_width(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/mem_squash_ctrl_updown_counter.sv
// Up/down counter with a load path and asynchronous active-low clear.
// load has priority; simultaneous inc and dec cancel out.
module updown_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise net increment/decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (inc_i && !dec_i)
            cnt_d = cnt_q + W'(1);
        else if (dec_i && !inc_i)
            cnt_d = cnt_q - W'(1);
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_squash_ctrl.sv
// Outstanding-request tracker between a pipeline stage and an in-order
// memory port. Throttles at p_max_inflight and, on squash, silently
// consumes the responses of every request issued before the squash cycle.
module mem_squash_ctrl
    import mem_squash_pkg::*;
#(
    parameter int p_req_nbits    = 77,
    parameter int p_resp_nbits   = 47,
    parameter int p_max_inflight = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    squash,
    input  logic [p_req_nbits-1:0]  ireq_msg,
    input  logic                    ireq_val,
    output logic                    ireq_rdy,
    output logic [p_req_nbits-1:0]  oreq_msg,
    output logic                    oreq_val,
    input  logic                    oreq_rdy,
    input  logic [p_resp_nbits-1:0] iresp_msg,
    input  logic                    iresp_val,
    output logic                    iresp_rdy,
    output logic [p_resp_nbits-1:0] oresp_msg,
    output logic                    oresp_val,
    input  logic                    oresp_rdy,
    output logic [$clog2(p_max_inflight+1)-1:0] inflight,
    output logic                    dropping
);

    localparam int W = cnt_width(p_max_inflight);

    logic [W-1:0] cnt_q, drop_cnt_q, cnt_after_resp;
    logic         not_full, drop_now, req_go, resp_go, resp_dec;
    state_e       state;

    // Drop state is derived straight from the drop counter.
    always_comb begin
        state = STATE_PASS;
        if (drop_cnt_q != '0)
            state = STATE_DROP;
    end

    // Handshake gating; everything is forced quiet while reset is held.
    always_comb begin
        not_full  = cnt_q < W'(p_max_inflight);
        drop_now  = squash || (state == STATE_DROP);
        oreq_val  = reset && ireq_val && not_full;
        ireq_rdy  = reset && oreq_rdy && not_full;
        oresp_val = reset && iresp_val && !drop_now;
        iresp_rdy = reset && (drop_now ? 1'b1 : oresp_rdy);
        req_go    = oreq_val && oreq_rdy;
        resp_go   = iresp_val && iresp_rdy;
        // A response with nothing outstanding must not wrap the counter.
        resp_dec       = resp_go && (cnt_q != '0);
        cnt_after_resp = cnt_q - W'(resp_dec);
    end

    assign oreq_msg  = ireq_msg;
    assign oresp_msg = iresp_msg;
    assign inflight  = cnt_q;
    assign dropping  = (state == STATE_DROP);

    updown_counter #(.W(W)) u_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .inc_i      (req_go),
        .dec_i      (resp_dec),
        .load_i     (1'b0),
        .load_val_i ('0),
        .cnt_o      (cnt_q)
    );

    // On squash, mark every older request (already-marked ones included);
    // the squash-cycle request is younger and is not counted.
    updown_counter #(.W(W)) u_drop_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .inc_i      (1'b0),
        .dec_i      (resp_go && (state == STATE_DROP)),
        .load_i     (squash),
        .load_val_i (cnt_after_resp),
        .cnt_o      (drop_cnt_q)
    );

    // A response with no outstanding request breaks the memory contract.
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(iresp_val && (cnt_q == '0)));

endmodule

// File: tb/tb_mem_squash_ctrl.sv
// Directed self-checking bench for mem_squash_ctrl (p_max_inflight = 4).
module tb_mem_squash_ctrl;

    localparam int RQ = 77;
    localparam int RS = 47;
    localparam int MX = 4;
    localparam int W  = $clog2(MX + 1);

    logic          clk, reset, squash;
    logic [RQ-1:0] ireq_msg, oreq_msg;
    logic          ireq_val, ireq_rdy, oreq_val, oreq_rdy;
    logic [RS-1:0] iresp_msg, oresp_msg;
    logic          iresp_val, iresp_rdy, oresp_val, oresp_rdy;
    logic [W-1:0]  inflight;
    logic          dropping;

    int checks   = 0;
    int failures = 0;

    mem_squash_ctrl #(.p_req_nbits(RQ), .p_resp_nbits(RS), .p_max_inflight(MX)) dut (
        .clk(clk), .reset(reset), .squash(squash),
        .ireq_msg(ireq_msg), .ireq_val(ireq_val), .ireq_rdy(ireq_rdy),
        .oreq_msg(oreq_msg), .oreq_val(oreq_val), .oreq_rdy(oreq_rdy),
        .iresp_msg(iresp_msg), .iresp_val(iresp_val), .iresp_rdy(iresp_rdy),
        .oresp_msg(oresp_msg), .oresp_val(oresp_val), .oresp_rdy(oresp_rdy),
        .inflight(inflight), .dropping(dropping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int n);
        for (int i = 0; i < n; i++) begin
            ireq_val = 1'b1;
            ireq_msg = RQ'(32'hA000 + i);
            tick();
        end
        ireq_val = 1'b0;
    endtask

    task automatic respond(input int n);
        for (int i = 0; i < n; i++) begin
            iresp_val = 1'b1;
            iresp_msg = RS'(32'hB000 + i);
            tick();
        end
        iresp_val = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; squash = 1'b0;
        ireq_val = 1'b1; oreq_rdy = 1'b1; iresp_val = 1'b1; oresp_rdy = 1'b1;
        ireq_msg = '0; iresp_msg = '0;
        tick(); tick();
        checks++; if (ireq_rdy !== 1'b0) begin failures++; $display("FAIL reset_ireq_rdy got=%b exp=0", ireq_rdy); end
        checks++; if (oreq_val !== 1'b0) begin failures++; $display("FAIL reset_oreq_val got=%b exp=0", oreq_val); end
        checks++; if (iresp_rdy !== 1'b0) begin failures++; $display("FAIL reset_iresp_rdy got=%b exp=0", iresp_rdy); end
        checks++; if (oresp_val !== 1'b0) begin failures++; $display("FAIL reset_oresp_val got=%b exp=0", oresp_val); end
        checks++; if (inflight !== W'(0)) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
        checks++; if (dropping !== 1'b0) begin failures++; $display("FAIL reset_dropping got=%b exp=0", dropping); end
        ireq_val = 1'b0; iresp_val = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_pass;
        for (int i = 0; i < 3; i++) begin
            ireq_val = 1'b1; ireq_msg = RQ'(64'h1234_0000_0000 + i);
            #1;
            checks++; if (oreq_val !== 1'b1 || oreq_msg !== RQ'(64'h1234_0000_0000 + i)) begin
                failures++; $display("FAIL basic_req%0d got val=%b msg=%0h", i, oreq_val, oreq_msg); end
            tick();
            checks++; if (inflight !== W'(i + 1)) begin failures++; $display("FAIL basic_inflight_up got=%0d exp=%0d", inflight, i + 1); end
        end
        ireq_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iresp_val = 1'b1; iresp_msg = RS'(48'h55_0000 + i);
            #1;
            checks++; if (oresp_val !== 1'b1 || oresp_msg !== RS'(48'h55_0000 + i)) begin
                failures++; $display("FAIL basic_resp%0d got val=%b msg=%0h", i, oresp_val, oresp_msg); end
            tick();
            checks++; if (inflight !== W'(2 - i) || dropping !== 1'b0) begin
                failures++; $display("FAIL basic_inflight_down got=%0d/%b exp=%0d/0", inflight, dropping, 2 - i); end
        end
        iresp_val = 1'b0;
    endtask

    task automatic test_full_throttle;
        issue(4);
        checks++; if (inflight !== W'(4)) begin failures++; $display("FAIL full_inflight got=%0d exp=4", inflight); end
        ireq_val = 1'b1; ireq_msg = RQ'(5);
        #1;
        checks++; if (ireq_rdy !== 1'b0 || oreq_val !== 1'b0) begin
            failures++; $display("FAIL full_stall got rdy=%b val=%b exp 0/0", ireq_rdy, oreq_val); end
        iresp_val = 1'b1;
        #1;
        checks++; if (oresp_val !== 1'b1 || oreq_val !== 1'b0) begin
            failures++; $display("FAIL full_no_bypass got oresp_val=%b oreq_val=%b exp 1/0", oresp_val, oreq_val); end
        tick();
        iresp_val = 1'b0;
        checks++; if (inflight !== W'(3)) begin failures++; $display("FAIL full_release got=%0d exp=3", inflight); end
        #1;
        checks++; if (oreq_val !== 1'b1 || ireq_rdy !== 1'b1) begin
            failures++; $display("FAIL full_fifth_issue got val=%b rdy=%b exp 1/1", oreq_val, ireq_rdy); end
        tick();
        ireq_val = 1'b0;
        checks++; if (inflight !== W'(4)) begin failures++; $display("FAIL full_refill got=%0d exp=4", inflight); end
        respond(1);
        ireq_val = 1'b1; iresp_val = 1'b1;
        tick();
        ireq_val = 1'b0; iresp_val = 1'b0;
        checks++; if (inflight !== W'(3)) begin failures++; $display("FAIL full_req_resp_same got=%0d exp=3", inflight); end
        respond(3);
        checks++; if (inflight !== W'(0)) begin failures++; $display("FAIL full_drain got=%0d exp=0", inflight); end
    endtask

    task automatic test_multi_drop;
        issue(3);
        squash = 1'b1; ireq_val = 1'b1; oresp_rdy = 1'b0;
        #1;
        checks++; if (oreq_val !== 1'b1) begin failures++; $display("FAIL mdrop_squash_req got=%b exp=1", oreq_val); end
        tick();
        squash = 1'b0; ireq_val = 1'b0;
        checks++; if (inflight !== W'(4) || dropping !== 1'b1) begin
            failures++; $display("FAIL mdrop_start got=%0d/%b exp=4/1", inflight, dropping); end
        for (int i = 0; i < 3; i++) begin
            iresp_val = 1'b1;
            #1;
            checks++; if (oresp_val !== 1'b0 || iresp_rdy !== 1'b1) begin
                failures++; $display("FAIL mdrop_discard%0d got val=%b rdy=%b exp 0/1", i, oresp_val, iresp_rdy); end
            tick();
            checks++; if (dropping !== (i < 2)) begin failures++; $display("FAIL mdrop_dropping%0d got=%b exp=%b", i, dropping, i < 2); end
        end
        checks++; if (inflight !== W'(1)) begin failures++; $display("FAIL mdrop_left got=%0d exp=1", inflight); end
        oresp_rdy = 1'b1; iresp_msg = RS'(48'hDEAD);
        #1;
        checks++; if (oresp_val !== 1'b1 || oresp_msg !== RS'(48'hDEAD)) begin
            failures++; $display("FAIL mdrop_fourth got val=%b msg=%0h", oresp_val, oresp_msg); end
        tick();
        iresp_val = 1'b0;
        checks++; if (inflight !== W'(0)) begin failures++; $display("FAIL mdrop_end got=%0d exp=0", inflight); end
    endtask

    task automatic test_same_cycle_squash;
        issue(2);
        squash = 1'b1; iresp_val = 1'b1;
        #1;
        checks++; if (oresp_val !== 1'b0 || iresp_rdy !== 1'b1) begin
            failures++; $display("FAIL same_drop got val=%b rdy=%b exp 0/1", oresp_val, iresp_rdy); end
        tick();
        squash = 1'b0;
        checks++; if (inflight !== W'(1) || dropping !== 1'b1) begin
            failures++; $display("FAIL same_after got=%0d/%b exp=1/1", inflight, dropping); end
        #1;
        checks++; if (oresp_val !== 1'b0) begin failures++; $display("FAIL same_second_drop got=%b exp=0", oresp_val); end
        tick();
        iresp_val = 1'b0;
        checks++; if (inflight !== W'(0) || dropping !== 1'b0) begin
            failures++; $display("FAIL same_end got=%0d/%b exp=0/0", inflight, dropping); end
    endtask

    task automatic test_resquash;
        issue(2);
        squash = 1'b1; tick(); squash = 1'b0;
        checks++; if (dropping !== 1'b1) begin failures++; $display("FAIL resq_first got=%b exp=1", dropping); end
        issue(2);
        checks++; if (inflight !== W'(4)) begin failures++; $display("FAIL resq_inflight got=%0d exp=4", inflight); end
        squash = 1'b1; tick(); squash = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iresp_val = 1'b1;
            #1;
            checks++; if (oresp_val !== 1'b0) begin failures++; $display("FAIL resq_discard%0d got=%b exp=0", i, oresp_val); end
            tick();
            iresp_val = 1'b0;
            checks++; if (dropping !== (i < 3)) begin failures++; $display("FAIL resq_dropping%0d got=%b exp=%b", i, dropping, i < 3); end
        end
        checks++; if (inflight !== W'(0)) begin failures++; $display("FAIL resq_end got=%0d exp=0", inflight); end
        issue(1);
        iresp_val = 1'b1;
        #1;
        checks++; if (oresp_val !== 1'b1) begin failures++; $display("FAIL resq_pass_again got=%b exp=1", oresp_val); end
        tick();
        iresp_val = 1'b0;
    endtask

    task automatic test_squash_empty;
        squash = 1'b1; ireq_val = 1'b1;
        #1;
        checks++; if (oreq_val !== 1'b1) begin failures++; $display("FAIL empty_req got=%b exp=1", oreq_val); end
        tick();
        squash = 1'b0; ireq_val = 1'b0;
        checks++; if (dropping !== 1'b0 || inflight !== W'(1)) begin
            failures++; $display("FAIL empty_state got=%0d/%b exp=1/0", inflight, dropping); end
        iresp_val = 1'b1;
        #1;
        checks++; if (oresp_val !== 1'b1) begin failures++; $display("FAIL empty_resp got=%b exp=1", oresp_val); end
        tick();
        iresp_val = 1'b0;
    endtask

    task automatic test_async_reset;
        issue(2);
        squash = 1'b1; tick(); squash = 1'b0;
        checks++; if (dropping !== 1'b1) begin failures++; $display("FAIL areset_pre got=%b exp=1", dropping); end
        ireq_val = 1'b1; iresp_val = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++; if ({ireq_rdy, oreq_val, iresp_rdy, oresp_val} !== 4'b0000) begin
            failures++; $display("FAIL areset_outs got=%b exp=0000", {ireq_rdy, oreq_val, iresp_rdy, oresp_val}); end
        checks++; if (inflight !== W'(0) || dropping !== 1'b0) begin
            failures++; $display("FAIL areset_state got=%0d/%b exp=0/0", inflight, dropping); end
        tick();
        ireq_val = 1'b0; iresp_val = 1'b0; reset = 1'b1;
        tick();
        ireq_val = 1'b1; ireq_msg = RQ'(32'hCAFE);
        #1;
        checks++; if (oreq_val !== 1'b1 || oreq_msg !== RQ'(32'hCAFE)) begin
            failures++; $display("FAIL areset_req got val=%b msg=%0h", oreq_val, oreq_msg); end
        tick();
        ireq_val = 1'b0;
        checks++; if (inflight !== W'(1)) begin failures++; $display("FAIL areset_inflight got=%0d exp=1", inflight); end
        iresp_val = 1'b1; iresp_msg = RS'(32'hBEEF);
        #1;
        checks++; if (oresp_val !== 1'b1 || oresp_msg !== RS'(32'hBEEF)) begin
            failures++; $display("FAIL areset_resp got val=%b msg=%0h", oresp_val, oresp_msg); end
        tick();
        iresp_val = 1'b0;
        checks++; if (inflight !== W'(0)) begin failures++; $display("FAIL areset_end got=%0d exp=0", inflight); end
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_full_throttle();
        test_multi_drop();
        test_same_cycle_squash();
        test_resquash();
        test_squash_empty();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
